// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned WB_AW = 8;
  localparam int unsigned WB_DW = 8;

  typedef enum logic [0:0] {
    IDLE,
    OWN
  } arb_state_t;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Single Wishbone slave-side bus bundle with X-checks on the request payload.
interface wb_if
  import wb_arb_pkg::*;
(
  input logic clk_i
);

  logic             cyc;
  logic             stb;
  logic             we;
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] dat_m2s;
  logic [WB_DW-1:0] dat_s2m;
  logic             ack;

  modport master (
    output cyc, stb, we, adr, dat_m2s,
    input  dat_s2m, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_m2s,
    output dat_s2m, ack
  );

  // An active strobe must carry a known address, and known data on writes.
  always_ff @(posedge clk_i) begin
    if (cyc && stb) begin
      assert (!$isunknown(adr));
      if (we) begin
        assert (!$isunknown(dat_m2s));
      end
    end
  end

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first requester strictly after last_i wins.
module rr_pick #(
  parameter int unsigned NUM_M = 2,
  localparam int unsigned IdxW = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned       cand;
  logic [IdxW-1:0]   cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offset NUM_M wraps back to last_i itself, so it only wins when it is the sole requester.
    for (int unsigned off = 1; off <= NUM_M; off++) begin
      cand     = (32'(last_i) + off) % NUM_M;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one 8-bit slave shared by NUM_M masters, per-CYC ownership,
// with a per-access timeout that returns a one-cycle error pulse to the owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_M   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NUM_M-1:0]       M_CYC,
  input  logic [NUM_M-1:0]       M_STB,
  input  logic [NUM_M-1:0]       M_WE,
  input  logic [NUM_M*WB_AW-1:0] M_ADR,
  input  logic [NUM_M*WB_DW-1:0] M_DATA_O,
  output logic [WB_DW-1:0]       M_DATA_I,
  output logic [NUM_M-1:0]       M_ACK,
  output logic [NUM_M-1:0]       M_ERR,
  output logic                   S_CYC,
  output logic                   S_STB,
  output logic                   S_WE,
  output logic [WB_AW-1:0]       S_ADR,
  output logic [WB_DW-1:0]       S_DATA_O,
  input  logic [WB_DW-1:0]       S_DATA_I,
  input  logic                   S_ACK,
  output logic [NUM_M-1:0]       GNT,
  output logic                   BUSY
);

  localparam int unsigned IdxW = $clog2(NUM_M);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NUM_M-1:0] err_q, err_d;

  logic [NUM_M-1:0] pick_gnt;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_valid;

  rr_pick #(
    .NUM_M (NUM_M)
  ) u_rr_pick (
    .req_i   (M_CYC),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // In OWN, last_q holds the owner index.
  always_comb begin
    S_CYC    = 1'b0;
    S_STB    = 1'b0;
    S_WE     = 1'b0;
    S_ADR    = '0;
    S_DATA_O = '0;
    M_ACK    = '0;
    if (state_q == OWN) begin
      S_CYC    = M_CYC[last_q];
      S_STB    = M_STB[last_q] & ~(|err_q);
      S_WE     = M_WE[last_q];
      S_ADR    = M_ADR[last_q*WB_AW +: WB_AW];
      S_DATA_O = M_DATA_O[last_q*WB_DW +: WB_DW];
      M_ACK    = gnt_q & {NUM_M{S_ACK}};
    end
  end

  assign M_DATA_I = S_DATA_I;
  assign M_ERR    = err_q;
  assign GNT      = gnt_q;
  assign BUSY     = |gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
        end
      end
      OWN: begin
        // An ACK on the terminal count falls outside this branch, so ACK beats timeout.
        if (S_STB && !S_ACK) begin
          if (cnt_q == CntW'(TIMEOUT)) begin
            err_d = gnt_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (!M_CYC[last_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IdxW'(NUM_M - 1);
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with two masters and TIMEOUT=16.
module tb_wb_rr_arbiter;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dato;
  logic [7:0]  m_dati;
  logic [1:0]  m_ack, m_err, gnt;
  logic        busy;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_if bus (.clk_i(clk));

  // Zero-wait slave model: acknowledges a live strobe whenever enabled.
  assign bus.ack     = ack_en & bus.stb;
  assign bus.dat_s2m = 8'hC3;

  wb_rr_arbiter #(
    .NUM_M   (2),
    .TIMEOUT (16)
  ) dut (
    .CLK      (clk),
    .RSTN     (rstn),
    .M_CYC    (m_cyc),
    .M_STB    (m_stb),
    .M_WE     (m_we),
    .M_ADR    (m_adr),
    .M_DATA_O (m_dato),
    .M_DATA_I (m_dati),
    .M_ACK    (m_ack),
    .M_ERR    (m_err),
    .S_CYC    (bus.cyc),
    .S_STB    (bus.stb),
    .S_WE     (bus.we),
    .S_ADR    (bus.adr),
    .S_DATA_O (bus.dat_m2s),
    .S_DATA_I (bus.dat_s2m),
    .S_ACK    (bus.ack),
    .GNT      (gnt),
    .BUSY     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] exp_g [8];

  initial begin
    exp_g = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    rstn   = 1'b0;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    m_adr  = '0;
    m_dato = '0;
    ack_en = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scyc", bus.cyc, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    rstn = 1'b1;

    // Master 0 single write, slave ACKs two cycles into the grant
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr[7:0] = 8'h02; m_dato[7:0] = 8'hA5;
    #1;
    chk("t1_gnt_pre", gnt, 0);
    step();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_adr", bus.adr, 8'h02);
    chk("t1_dat", bus.dat_m2s, 8'hA5);
    chk("t1_we", bus.we, 1);
    chk("t1_ack_wait", m_ack, 0);
    step();
    chk("t1_ack_wait2", m_ack, 0);
    step();
    ack_en = 1'b1;
    #1;
    chk("t1_ack", m_ack, 2'b01);
    chk("t1_rdata", m_dati, 8'hC3);
    step();
    ack_en = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    #1;
    chk("t1_ack_drop", m_ack, 0);
    chk("t1_gnt_hold", gnt, 2'b01);
    chk("t1_scyc_drop", bus.cyc, 0);
    step();
    chk("t1_release", gnt, 0);

    // Both masters request continuously with single-beat cycles
    ack_en = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = 16'h1110; m_dato = 16'h2220;
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("t2_gnt%0d", n), gnt, exp_g[n]);
      chk($sformatf("t2_ack%0d", n), m_ack, exp_g[n]);
      if (exp_g[n] != 2'b00) begin
        m_cyc = m_cyc & ~exp_g[n];
        m_stb = m_stb & ~exp_g[n];
      end else begin
        m_cyc = 2'b11;
        m_stb = 2'b11;
      end
    end
    m_cyc = '0; m_stb = '0; ack_en = 1'b0;

    // Master 1 owns; master 0 asks mid-cycle and must wait
    m_cyc = 2'b10; m_stb = 2'b10;
    m_adr = 16'h3344; m_dato = 16'h5A00;
    step();
    chk("t3_gnt1", gnt, 2'b10);
    chk("t3_adr1", bus.adr, 8'h33);
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    chk("t3_adr_stable", bus.adr, 8'h33);
    chk("t3_scyc_stable", bus.cyc, 1);
    step();
    chk("t3_gnt_keep", gnt, 2'b10);
    ack_en = 1'b1;
    #1;
    chk("t3_ack1", m_ack, 2'b10);
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    chk("t3_idle", gnt, 0);
    chk("t3_idle_scyc", bus.cyc, 0);
    step();
    chk("t3_gnt0", gnt, 2'b01);
    chk("t3_adr0", bus.adr, 8'h44);
    chk("t3_ack0", m_ack, 2'b01);
    m_cyc = '0; m_stb = '0;
    step();
    chk("t3_release", gnt, 0);
    ack_en = 1'b0;

    // Slave never ACKs: error 17 cycles after the strobe rises
    m_cyc = 2'b01; m_stb = 2'b01; m_we = '0;
    for (int j = 0; j <= 16; j++) begin
      step();
      chk($sformatf("t4_noerr%0d", j), m_err, 0);
    end
    step();
    chk("t4_err", m_err, 2'b01);
    chk("t4_stb_forced", bus.stb, 0);
    chk("t4_no_ack", m_ack, 0);
    chk("t4_gnt", gnt, 2'b01);
    step();
    chk("t4_err_pulse", m_err, 0);
    chk("t4_stb_back", bus.stb, 1);
    m_cyc = '0; m_stb = '0;
    step();
    chk("t4_release", gnt, 0);

    // ACK lands on the terminal-count cycle
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int j = 0; j <= 15; j++) begin
      step();
    end
    step();
    ack_en = 1'b1;
    #1;
    chk("t5_ack", m_ack, 2'b01);
    chk("t5_err_same", m_err, 0);
    step();
    ack_en = 1'b0;
    #1;
    chk("t5_no_err", m_err, 0);
    chk("t5_stb_live", bus.stb, 1);
    m_cyc = '0; m_stb = '0;
    step();
    chk("t5_release", gnt, 0);

    // Reset during master 1 read; master 0 wins the tie afterwards
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    chk("t6_gnt1", gnt, 2'b10);
    chk("t6_scyc", bus.cyc, 1);
    rstn = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_scyc", bus.cyc, 0);
    rstn = 1'b1;
    step();
    chk("t6_tie", gnt, 2'b01);
    m_cyc = '0; m_stb = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
